// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - RV32I single-cycle ALU with iterative RV32M multiply/divide engine
module alu_iterative #(
    parameter int WIDTH = 32,
    parameter int M_EXT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = CW - 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [2:0]       kind;
    logic             neg_q, neg_r, div_zero;

    logic             is_iter, accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_out;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_rem;
    logic             div_fits;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] mulh_neg, q_neg, r_neg, final_res;

    assign is_iter = (M_EXT != 0) && (op[4:3] == 2'b10);
    assign accept  = start && (state != CALC);
    assign busy    = (state == CALC);

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    assign shamt = b[SW-1:0];

    always_comb begin
        alu_out = '0;
        case (op)
            5'd0:    alu_out = a + b;
            5'd1:    alu_out = a - b;
            5'd2:    alu_out = a << shamt;
            5'd3:    alu_out = {{(WIDTH-1){1'b0}}, lt};
            5'd4:    alu_out = {{(WIDTH-1){1'b0}}, ltu};
            5'd5:    alu_out = a ^ b;
            5'd6:    alu_out = a >> shamt;
            5'd7:    alu_out = $signed(a) >>> shamt;
            5'd8:    alu_out = a | b;
            5'd9:    alu_out = a & b;
            default: alu_out = '0;
        endcase
    end

    // Signed operand of MULH/MULHSU/DIV/REM (a) and MULH/DIV/REM (b) become magnitudes.
    assign sa    = a[WIDTH-1] && (op[2:0] == 3'd1 || op[2:0] == 3'd2 ||
                                  op[2:0] == 3'd4 || op[2:0] == 3'd6);
    assign sb    = b[WIDTH-1] && (op[2:0] == 3'd1 || op[2:0] == 3'd4 || op[2:0] == 3'd6);
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // Shift-add: {hi,lo} shifts right, lo holds the multiplier, opnd the multiplicand.
    assign mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};
    // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, opnd});
    assign div_rem   = div_shift[WIDTH-1:0] - opnd;

    always_comb begin
        if (kind[2]) begin
            step_hi = div_fits ? div_rem : div_shift[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], div_fits};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // High half of the negated double-width product without forming the low half.
    assign mulh_neg = ~step_hi + {{(WIDTH-1){1'b0}}, (step_lo == '0)};
    assign q_neg    = -step_lo;
    assign r_neg    = -step_hi;

    always_comb begin
        final_res = '0;
        case (kind)
            3'd0:    final_res = step_lo;
            3'd1,
            3'd2:    final_res = neg_q ? mulh_neg : step_hi;
            3'd3:    final_res = step_hi;
            3'd4:    final_res = div_zero ? '1 : (neg_q ? q_neg : step_lo);
            3'd5:    final_res = step_lo;
            3'd6:    final_res = neg_r ? r_neg : step_hi;
            default: final_res = step_hi;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, FIN: state_next = (start && is_iter) ? CALC : IDLE;
            CALC:      if (cnt == CNT_ONE) state_next = FIN;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            kind     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && is_iter) begin
                cnt      <= CNT_INIT;
                kind     <= op[2:0];
                hi       <= '0;
                lo       <= op[2] ? mag_a : mag_b;
                opnd     <= op[2] ? mag_b : mag_a;
                neg_q    <= sa ^ sb;
                neg_r    <= sa;
                div_zero <= (b == '0);
            end else if (accept) begin
                result <= alu_out;
                done   <= 1'b1;
            end else if (busy) begin
                cnt <= cnt - CNT_ONE;
                hi  <= step_hi;
                lo  <= step_lo;
                if (cnt == CNT_ONE) begin
                    result <= final_res;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - randomized and directed self-checking bench for alu_iterative
module tb_alu_iterative;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] result;
    logic        done, busy, eq, lt, ltu;

    logic        start_n = 1'b0, start_m = 1'b0;
    logic [4:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  res_n, res_m;
    logic        done_n, busy_n, eq_n, lt_n, ltu_n;
    logic        done_m, busy_m, eq_m, lt_m, ltu_m;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_iterative #(.WIDTH(32), .M_EXT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .done(done), .busy(busy), .eq(eq), .lt(lt), .ltu(ltu)
    );

    alu_iterative #(.WIDTH(8), .M_EXT(0)) dut8n (
        .clk(clk), .rst(rst), .start(start_n), .op(op8), .a(a8), .b(b8),
        .result(res_n), .done(done_n), .busy(busy_n), .eq(eq_n), .lt(lt_n), .ltu(ltu_n)
    );

    alu_iterative #(.WIDTH(8), .M_EXT(1)) dut8m (
        .clk(clk), .rst(rst), .start(start_m), .op(op8), .a(a8), .b(b8),
        .result(res_m), .done(done_m), .busy(busy_m), .eq(eq_m), .lt(lt_m), .ltu(ltu_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx = $signed(x);
        longint          sy = $signed(y);
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        longint          ps;
        longint unsigned pu;
        logic [31:0]     r;
        case (o)
            5'd0:  r = x + y;
            5'd1:  r = x - y;
            5'd2:  r = x << y[4:0];
            5'd3:  r = (sx < sy) ? 32'd1 : 32'd0;
            5'd4:  r = (x < y) ? 32'd1 : 32'd0;
            5'd5:  r = x ^ y;
            5'd6:  r = x >> y[4:0];
            5'd7:  r = $signed(x) >>> y[4:0];
            5'd8:  r = x | y;
            5'd9:  r = x & y;
            5'd16: r = x * y;
            5'd17: begin ps = sx * sy;          r = ps[63:32]; end
            5'd18: begin ps = sx * longint'(ux); r = ps[63:32]; end
            5'd19: begin pu = ux * uy;          r = pu[63:32]; end
            5'd20: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else begin ps = sx / sy; r = ps[31:0]; end
            end
            5'd21: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd22: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else begin ps = sx % sy; r = ps[31:0]; end
            end
            5'd23: r = (y == 0) ? x : x % y;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = $urandom_range(0, 40);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op, return its result, cycles to done, busy-profile errors and done level one cycle later.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output int busy_bad,
                          output logic done_after);
        bit iter;
        iter = (o >= 5'd16 && o <= 5'd23);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy !== (iter && c <= 32)) busy_bad++;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        res = result;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic exec(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
        logic [31:0] res;
        int          lat, bb;
        logic        da;
        run_op(o, x, y, res, lat, bb, da);
        check({tag, ".result"}, res, exp);
        check({tag, ".latency"}, lat, (o >= 5'd16 && o <= 5'd23) ? 32'd33 : 32'd1);
        check({tag, ".busy"}, bb, 32'd0);
        check({tag, ".done_pulse"}, {31'd0, da}, 32'd0);
    endtask

    initial begin
        logic [4:0]  o;
        logic [31:0] x, y;
        int          cnt_done, lat;
        logic [4:0]  bb_op[4];
        logic [31:0] bb_a[4], bb_b[4], bb_exp[4];

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.result", result, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Reset mid-operation
        exec("pre_add", 5'd0, 32'd20, 32'd22, 32'd42);
        @(negedge clk);
        op = 5'd16; a = 32'd5; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.busy", {31'd0, busy}, 32'd0);
        check("rst_mid.result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) cnt_done++;
        end
        check("rst_mid.no_done", cnt_done, 32'd0);
        exec("post_rst_add", 5'd0, 32'd1, 32'd2, 32'd3);

        // Single-cycle back-to-back
        bb_op = '{5'd0, 5'd1, 5'd7, 5'd4};
        bb_a  = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd1};
        bb_b  = '{32'd1, 32'd1, 32'd4, 32'hFFFF_FFFF};
        bb_exp = '{32'h0, 32'hFFFF_FFFF, 32'hF800_0000, 32'h1};
        @(negedge clk);
        op = bb_op[0]; a = bb_a[0]; b = bb_b[0]; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b%0d.result", k), result, bb_exp[k]);
            check($sformatf("b2b%0d.done_busy", k), {30'd0, done, busy}, 32'd2);
            if (k < 3) begin
                op = bb_op[k+1]; a = bb_a[k+1]; b = bb_b[k+1];
            end else begin
                start = 1'b0;
            end
        end

        // Multiply family and divide special cases
        exec("mulh_min", 5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        exec("mulhu_max", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        exec("mulhsu_neg", 5'd18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        exec("mul_7_m3", 5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        exec("div_m7_2", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        exec("rem_m7_2", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        exec("divu_by0", 5'd21, 32'd10, 32'd0, 32'hFFFF_FFFF);
        exec("remu_by0", 5'd23, 32'd10, 32'd0, 32'd10);
        exec("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        exec("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        exec("div_by0", 5'd20, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        exec("rem_by0", 5'd22, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        exec("illegal", 5'd12, 32'd5, 32'd6, 32'd0);

        // Handshake: starts and operand changes while busy are ignored
        @(negedge clk);
        op = 5'd20; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            check($sformatf("hs%0d.busy_done", i), {30'd0, busy, done}, 32'd2);
            op = 5'd0;
            a = $urandom;
            b = (i % 4 == 0) ? a : ((i % 3 == 0) ? ~a : $urandom);
            start = 1'b1;
            #1;
            check($sformatf("hs%0d.flags", i), {29'd0, eq, lt, ltu},
                  {29'd0, a == b, $signed(a) < $signed(b), a < b});
        end
        @(negedge clk);
        start = 1'b0;
        check("hs.done", {31'd0, done}, 32'd1);
        check("hs.result", result, 32'd14);
        @(negedge clk);
        check("hs.done_after", {31'd0, done}, 32'd0);
        check("hs.result_held", result, 32'd14);

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) o = 5'($urandom_range(0, 31));
            else if ($urandom_range(0, 1) == 0) o = 5'($urandom_range(0, 9));
            else o = 5'($urandom_range(16, 23));
            x = pick();
            y = pick();
            exec($sformatf("rnd%0d_op%0d", n, o), o, x, y, ref32(o, x, y));
        end

        // WIDTH=8 instances: M_EXT=0 treats MUL as illegal, M_EXT=1 divides in 9 cycles
        @(negedge clk);
        op8 = 5'd16; a8 = 8'd3; b8 = 8'd3; start_n = 1'b1;
        @(posedge clk);
        #1 start_n = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done_n === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("w8_mext0_mul.result", {24'd0, res_n}, 32'd0);
        check("w8_mext0_mul.latency", lat, 32'd1);

        @(negedge clk);
        op8 = 5'd21; a8 = 8'd200; b8 = 8'd7; start_m = 1'b1;
        @(posedge clk);
        #1 start_m = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done_m === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("w8_divu.result", {24'd0, res_m}, 32'd28);
        check("w8_divu.latency", lat, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
